// File: rtl/srt4_otf_converter.sv
// srt4_otf_converter: on-the-fly radix-4 SRT quotient digit to binary converter; define SRT4_OTF_FINAL_CORR_EN for remainder-sign correction
module srt4_otf_converter #(
  parameter int NUM_DIGITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      digit_valid,
  input  logic                      q_sign,
  input  logic [1:0]                q_mag,
  output logic                      digit_ready,
  input  logic                      rem_valid,
  input  logic                      rem_neg,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [2*NUM_DIGITS-1:0]   quotient,
  output logic                      busy,
  output logic                      err
);
  localparam int QW = 2 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, CONV, FINAL, DONE} state_e;
  state_e state_q, state_d;
  logic [QW-1:0] q_q, q_d, qm_q, qm_d, quot_q, quot_d, q_nx, qm_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic go, acc, last, zero, bad, fin;
  logic [1:0] mag, mag_neg;
  assign go      = state_q == IDLE && start;
  assign acc     = state_q == CONV && digit_valid;
  assign last    = acc && cnt_q == CW'(NUM_DIGITS - 1);
  assign bad     = q_mag == 2'b11;
  assign mag     = bad ? 2'b00 : q_mag;
  assign mag_neg = 2'd0 - mag;
  assign zero    = mag == 2'b00;
  // Q takes the QM branch for negative digits so no carry ever propagates; QM tracks Q-1
  assign q_nx  = zero ? {q_q[QW-3:0], 2'b00} : q_sign ? {qm_q[QW-3:0], mag_neg} : {q_q[QW-3:0], mag};
  assign qm_nx = zero ? {qm_q[QW-3:0], 2'b11} : q_sign ? {qm_q[QW-3:0], ~mag} : {q_q[QW-3:0], mag - 2'd1};
`ifdef SRT4_OTF_FINAL_CORR_EN
  assign fin = state_q == FINAL && rem_valid;
`else
  logic unused_rem;
  assign unused_rem = rem_valid ^ rem_neg;
  assign fin = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? CONV : IDLE;
`ifdef SRT4_OTF_FINAL_CORR_EN
      CONV: state_d = last ? FINAL : CONV;
      FINAL: state_d = rem_valid ? DONE : FINAL;
`else
      CONV: state_d = last ? DONE : CONV;
`endif
      DONE: state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    digit_ready  = state_q == CONV;
    busy         = state_q != IDLE;
    result_valid = state_q == DONE;
  end
  // datapath next values: init on start, shift on each accepted digit, capture result
  always_comb begin
    q_d    = go ? '0 : acc ? q_nx : q_q;
    qm_d   = go ? '1 : acc ? qm_nx : qm_q;
    cnt_d  = go ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
    err_d  = go ? 1'b0 : err_q | (acc & bad);
`ifdef SRT4_OTF_FINAL_CORR_EN
    quot_d = fin ? (rem_neg ? qm_q : q_q) : quot_q;
`else
    quot_d = last ? q_nx : quot_q;
`endif
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_q    <= '0;
      qm_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      quot_q <= '0;
    end else begin
      q_q    <= q_d;
      qm_q   <= qm_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      quot_q <= quot_d;
    end
  assign quotient = quot_q;
  assign err      = err_q;
endmodule

// File: doc/srt4_otf_converter.md
SRT4_OTF_CONVERTER -- requirements
Module: srt4_otf_converter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 16, meaning radix-4 digits per division; QW = 2*NUM_DIGITS is derived, not overridable.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begins a conversion when the block is in IDLE.
REQ-005 SHALL have port digit_valid, input, 1, a quotient digit is present.
REQ-006 SHALL have port q_sign, input, 1, digit sign (1 = negative).
REQ-007 SHALL have port q_mag, input, 2, digit magnitude from the selection PLA (00/01/10 legal).
REQ-008 SHALL have port digit_ready, output, 1, high only in CONV.
REQ-009 SHALL have port rem_valid, input, 1, final remainder sign is present.
REQ-010 SHALL have port rem_neg, input, 1, final partial remainder is negative.
REQ-011 SHALL have port result_valid, output, 1, quotient output is valid.
REQ-012 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port quotient, output, QW, converted binary quotient.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port err, output, 1, sticky illegal-digit flag for the current conversion.

Function
REQ-016 SHALL implement FSM states IDLE, CONV, FINAL, DONE: IDLE->CONV on start; CONV->FINAL (or DONE, see REQ-030) on acceptance of digit NUM_DIGITS; FINAL->DONE on rem_valid; DONE->IDLE on result_ready.
REQ-017 SHALL on start in IDLE set Q=0, QM=all ones (-1 mod 2^QW), digit counter=0, err=0.
REQ-018 SHALL accept a digit only on the cycle where digit_valid && digit_ready are both high; digit_valid in other states SHALL be ignored.
REQ-019 SHALL update per accepted digit d, with both registers shifted left 2 bits: d=+2: Q={Q,10}, QM={Q,01}; d=+1: Q={Q,01}, QM={Q,00}; d=0: Q={Q,00}, QM={QM,11}; d=-1: Q={QM,11}, QM={QM,10}; d=-2: Q={QM,10}, QM={QM,01}.
REQ-020 SHALL treat q_sign=1 with q_mag=00 as d=0.
REQ-021 SHALL on q_mag=11 set err and process the digit as d=0; the digit is still counted.
REQ-022 SHALL keep the invariant QM = Q-1 mod 2^QW after every accepted digit; upper bits shifted out are discarded.
REQ-023 SHALL in FINAL accept rem_valid and register quotient = rem_neg ? QM : Q.
REQ-024 SHALL assert result_valid exactly one cycle after the accepting edge (rem_valid in FINAL, or the last digit per REQ-030), and SHALL hold result_valid and quotient stable until result_ready is sampled high.
REQ-025 SHALL ignore start in any state other than IDLE, including DONE with result_ready low.
REQ-026 SHALL allow a DONE->IDLE transition and a new start on the following cycle, giving one idle cycle between conversions.
REQ-027 SHALL leave err readable in DONE and clear it only on the next start.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force state=IDLE, Q=0, QM=0, counter=0, quotient=0, result_valid=0, digit_ready=0, busy=0, err=0.
REQ-029 SHALL abandon any conversion in progress when reset is asserted; no partial result is emitted after rst_n deasserts.

Configuration
REQ-030 SHALL support macro SRT4_OTF_FINAL_CORR_EN: when defined, the FINAL state and remainder correction per REQ-023 are used; when undefined, FINAL is not built, rem_valid/rem_neg are ignored, CONV->DONE on the last digit, and quotient=Q.

Verification
REQ-031 SHALL cover NUM_DIGITS=2, digits +1,-2, rem_valid with rem_neg=0 -> quotient=4'h2; rerun with rem_neg=1 -> 4'h1.
REQ-032 SHALL cover NUM_DIGITS=16, 16 digits of +2, rem_neg=0 -> quotient=32'hAAAAAAAA, result_valid one cycle after rem_valid.
REQ-033 SHALL cover NUM_DIGITS=16, all digits 0 (including sign=1 mag=0), rem_neg=1 -> quotient=32'hFFFFFFFF, err=0.
REQ-034 SHALL cover a digit with q_mag=11 mid-stream -> err=1 in DONE; result equals the same stream with that digit replaced by 0; err=0 after the next start.
REQ-035 SHALL cover result_ready held low 5 cycles with start pulsed in DONE -> quotient stable, start ignored, IDLE after result_ready.
REQ-036 SHALL cover rst_n asserted after digit 7 of 16 -> all outputs 0 immediately; a new start yields a correct result.
